// File: rtl/seq_divider_if.sv
// Handshake and operand bundle for the multi-cycle divider.
// The master drives the request side, and the divider (slave) drives status and results.
interface seq_divider_if #(
    parameter int DATA_BUS = 16
);
    logic                enable;
    logic                start;
    logic [DATA_BUS:0]   dividend;
    logic [DATA_BUS-1:0] divisor;
    logic                busy;
    logic                done;
    logic [DATA_BUS:0]   quotient;
    logic [DATA_BUS-1:0] remainder;
    logic                div_by_zero;

    modport master (
        output enable, start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  enable, start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider: (DATA_BUS+1)-bit dividend over DATA_BUS-bit divisor.
// It retires one quotient bit per enabled cycle and uses a start/busy/done handshake.
module seq_divider #(
    parameter int NUM_WIDTH = 8,
    parameter int DATA_BUS  = 2 * NUM_WIDTH
) (
    input logic          clk,
    input logic          reset,
    seq_divider_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_BUS + 2);
    localparam logic [CNT_W-1:0] STEPS = CNT_W'(DATA_BUS + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_BUS-1:0] p_q, p_d;
    logic [DATA_BUS:0]   q_q, q_d;
    logic [DATA_BUS-1:0] divisor_q, divisor_d;
    logic [DATA_BUS:0]   quotient_q, quotient_d;
    logic [DATA_BUS-1:0] remainder_q, remainder_d;
    logic                dbz_q, dbz_d;

    logic [DATA_BUS:0]   trial;
    logic                take;
    logic [DATA_BUS-1:0] p_step;
    logic [DATA_BUS:0]   q_step;

    // The partial remainder always stays below the divisor, so DATA_BUS bits are enough to hold it.
    always_comb begin
        trial  = {p_q, q_q[DATA_BUS]};
        take   = (trial >= {1'b0, divisor_q});
        p_step = take ? DATA_BUS'(trial - {1'b0, divisor_q}) : trial[DATA_BUS-1:0];
        q_step = {q_q[DATA_BUS-1:0], take};

        state_d     = state_q;
        count_d     = count_q;
        p_d         = p_q;
        q_d         = q_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    divisor_d = bus.divisor;
                    if (bus.divisor != '0) begin
                        state_d = CALC;
                        count_d = STEPS;
                        p_d     = '0;
                        q_d     = bus.dividend;
                    end else begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = bus.dividend[DATA_BUS-1:0];
                        dbz_d       = 1'b1;
                    end
                end
            end
            CALC: begin
                p_d     = p_step;
                q_d     = q_step;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d     = DONE;
                    quotient_d  = q_step;
                    remainder_d = p_step;
                    dbz_d       = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset wins over enable; with enable low every register simply holds.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            p_q         <= '0;
            q_q         <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else if (bus.enable) begin
            state_q     <= state_d;
            count_q     <= count_d;
            p_q         <= p_d;
            q_q         <= q_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider.
// Expected results come from a queue-based scoreboard that is compared whenever done fires.
module tb_seq_divider;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [16:0] dvd;
        logic [15:0] dvs;
        logic [16:0] q;
        logic [15:0] r;
        logic        dbz;
    } exp_t;

    exp_t sb[$];

    logic [16:0] rnd_a;
    logic [15:0] rnd_b;
    int          done_seen;

    seq_divider_if #(.DATA_BUS(16)) bus ();

    seq_divider #(.NUM_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: a done that the next edge will retire is compared exactly once.
    always @(negedge clk) begin
        if (reset && bus.done && bus.enable) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done observed=1 expected=0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("quotient", 64'(bus.quotient), 64'(e.q));
                check_output("remainder", 64'(bus.remainder), 64'(e.r));
                check_output("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
                if (e.dvs != 16'd0) begin
                    check_output("invariant", 64'(bus.quotient) * 64'(e.dvs) + 64'(bus.remainder), 64'(e.dvd));
                    check_output("rem_lt_div", 64'(bus.remainder < e.dvs), 64'd1);
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [16:0] dvd, input logic [15:0] dvs,
                                  input int exp_lat, input int stall_at);
        exp_t e;
        int   n;
        int   busy_cnt;
        e.dvd = dvd;
        e.dvs = dvs;
        if (dvs == 16'd0) begin
            e.q   = '1;
            e.r   = dvd[15:0];
            e.dbz = 1'b1;
        end else begin
            e.q   = 17'(32'(dvd) / 32'(dvs));
            e.r   = 16'(32'(dvd) % 32'(dvs));
            e.dbz = 1'b0;
        end
        sb.push_back(e);
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        busy_cnt = 0;
        while (!bus.done && n < 200) begin
            if (bus.busy) busy_cnt++;
            tick();
            n++;
            if (stall_at > 0) begin
                if (n == stall_at) begin
                    bus.enable   = 1'b0;
                    bus.start    = 1'b1;
                    bus.dividend = 17'd7;
                    bus.divisor  = 16'd2;
                end else if (n == stall_at + 4) begin
                    bus.enable = 1'b1;
                end else if (n == stall_at + 5) begin
                    bus.start = 1'b0;
                end
            end
        end
        if (bus.busy) busy_cnt++;
        check_output("latency", 64'(n), 64'(exp_lat));
        check_output("busy_cycles", 64'(busy_cnt), 64'(exp_lat + 1));
        check_output("done_seen", 64'(bus.done), 64'd1);
    endtask

    task automatic finish_div();
        tick();
        check_output("idle_busy", 64'(bus.busy), 64'd0);
        check_output("idle_done", 64'(bus.done), 64'd0);
    endtask

    initial begin
        $display("[TB] start");
        reset        = 1'b0;
        bus.enable   = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick();
        tick();
        check_output("rst_busy", 64'(bus.busy), 64'd0);
        check_output("rst_done", 64'(bus.done), 64'd0);
        check_output("rst_quotient", 64'(bus.quotient), 64'd0);
        check_output("rst_remainder", 64'(bus.remainder), 64'd0);
        check_output("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        reset      = 1'b1;
        bus.enable = 1'b1;
        tick();

        apply_stimulus(17'd100, 16'd7, 17, 0);
        finish_div();

        apply_stimulus(17'd131071, 16'd1, 17, 0);
        bus.start    = 1'b1;
        bus.dividend = 17'd5;
        bus.divisor  = 16'd9;
        finish_div();
        apply_stimulus(17'd5, 16'd9, 17, 0);
        finish_div();

        apply_stimulus(17'd50, 16'd0, 0, 0);
        finish_div();
        check_output("hold_quotient", 64'(bus.quotient), 64'h1FFFF);
        check_output("hold_dbz", 64'(bus.div_by_zero), 64'd1);
        apply_stimulus(17'd40, 16'd8, 17, 0);
        finish_div();

        apply_stimulus(17'd1000, 16'd3, 21, 6);
        finish_div();

        bus.dividend = 17'd65535;
        bus.divisor  = 16'd255;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_output("abort_busy", 64'(bus.busy), 64'd0);
        check_output("abort_done", 64'(bus.done), 64'd0);
        check_output("abort_quotient", 64'(bus.quotient), 64'd0);
        check_output("abort_remainder", 64'(bus.remainder), 64'd0);
        check_output("abort_dbz", 64'(bus.div_by_zero), 64'd0);
        done_seen = 0;
        repeat (30) begin
            tick();
            if (bus.done) done_seen++;
        end
        check_output("abort_no_done", 64'(done_seen), 64'd0);
        apply_stimulus(17'd65535, 16'd255, 17, 0);
        finish_div();

        for (int i = 0; i < 2000; i++) begin
            case (i % 4)
                0: begin
                    rnd_a = 17'($urandom);
                    rnd_b = 16'($urandom);
                end
                1: begin
                    rnd_a = 17'($urandom);
                    rnd_b = 16'hFFFF;
                end
                2: begin
                    rnd_b = 16'($urandom_range(65535, 1));
                    rnd_a = 17'($urandom_range(32'(rnd_b) - 1, 0));
                end
                default: begin
                    rnd_a = 17'($urandom);
                    rnd_b = 16'($urandom_range(15, 0));
                end
            endcase
            apply_stimulus(rnd_a, rnd_b, (rnd_b == 16'd0) ? 0 : 17, 0);
            finish_div();
        end

        check_output("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider. It is the inverse of the registered adder stage: it takes a DATA_BUS+1-bit sum (accumulator/adder output width) and divides it by a DATA_BUS-bit divisor.
- Used for mean-pooling and normalisation in the neuron datapath.
- Produces one quotient bit per enabled cycle and reports completion with a start/busy/done handshake.

Parameters:
- NUM_WIDTH, 8, base operand width.
- DATA_BUS, 2*NUM_WIDTH (16), divisor/remainder width. Dividend and quotient are DATA_BUS+1 bits.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  clock-enable. When low, all state and outputs hold.
- start  input  1  request a division. Sampled only in IDLE with enable=1.
- dividend  input  DATA_BUS+1  unsigned numerator, captured on accept.
- divisor  input  DATA_BUS  unsigned denominator, captured on accept.
- busy  output  1  high from accept until the done cycle inclusive.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  DATA_BUS+1  unsigned quotient.
- remainder  output  DATA_BUS  unsigned remainder.
- div_by_zero  output  1  set with done when the captured divisor was 0.

Behaviour:
- Reset: reset is synchronous and active-low. On a clk edge with reset=0:
  - state=IDLE, and all internal registers are cleared.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Reset takes priority over enable and aborts any division in progress. No done is issued for the aborted division.
- enable=0: FSM, counter, working registers and outputs all freeze. A done pulse that is high stays high until the next enabled edge.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On an enabled edge with start=1, capture the operands and set busy=1.
  - If divisor≠0: go to CALC. Load bit counter=DATA_BUS+1 (17), partial remainder P=0 (DATA_BUS+1 bits), shift register Q=dividend.
  - If divisor=0: go directly to DONE with quotient=all ones, remainder=dividend[DATA_BUS-1:0], div_by_zero=1.
- CALC, each enabled edge (restoring step):
  - T={P[DATA_BUS-1:0],Q[MSB]}; Q<<=1.
  - If T≥divisor: P=T-divisor and Q[0]=1. Else P=T and Q[0]=0.
  - Compare at DATA_BUS+1 bits; no overflow is possible. Decrement the counter.
  - When the counter reaches 0 after the step: go to DONE, quotient=Q, remainder=P[DATA_BUS-1:0], div_by_zero=0.
- DONE:
  - done=1 and busy=1 for this state.
  - The next enabled edge returns to IDLE, with done=0 and busy=0.
  - start is ignored in DONE.
- Latency, with the accept edge as E0:
  - Normal division: done is visible after edge E17 (17 enabled cycles), and the FSM is back in IDLE after E18.
  - Zero divisor: done is visible after E0.
  - Back-to-back: a new start can be accepted on the edge after the done cycle, giving a throughput of 1 division per 19 enabled cycles.
- start while busy (CALC/DONE) is ignored, and the operand inputs are don't-care.
- quotient, remainder and div_by_zero hold their values after done until the next division completes or a reset occurs.
- Invariant on done: dividend = quotient*divisor + remainder, with remainder < divisor.

Test Plan:
- 100/7, enable=1: done pulses exactly 17 cycles after the accept edge; quotient=14, remainder=2, div_by_zero=0, busy high for 18 cycles.
- 131071/1 followed immediately by 5/9: first result quotient=131071, remainder=0; second start is accepted in IDLE right after the done cycle, giving quotient=0, remainder=5.
- 50/0: done one cycle after accept; quotient=0x1FFFF, remainder=50, div_by_zero=1. A following 40/8 gives quotient=5, remainder=0, div_by_zero=0.
- 1000/3 with enable toggled low for 4 cycles mid-CALC: done arrives 4 cycles late; quotient=333, remainder=1. start pulsed during CALC with other operands is ignored.
- reset=0 for one cycle at CALC step 9 of 65535/255: next cycle busy=0, done=0, outputs=0, and no done follows. A fresh 65535/255 then gives quotient=257, remainder=0.
- Random sweep of 2000 operand pairs, including divisor=0xFFFF and dividend<divisor: every done satisfies the quotient/remainder invariant.
